// File: rtl/ctrl_write_mode.sv
// rtl/ctrl_write_mode.sv - write-side sequencer loading the CVT bitmap table
// Accepts one bitmap per handshake and writes CVT entries 0..N_ENTRIES-1 in order.
module ctrl_write_mode #(
  parameter int N_ENTRIES = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_sel,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_SEL = ADDR_W'(N_ENTRIES - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(N_ENTRIES);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_counter;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_sel;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W:0]     r_wr_count;
  logic                w_in_ready;

  assign w_in_ready = (r_state == S_FILL);

  // abort outranks everything, so a beat taken in the abort cycle never reaches the CVT
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_counter  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (i_abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state    <= S_FILL;
              r_counter  <= '0;
              r_wr_count <= '0;
              r_busy     <= 1'b1;
            end
          end
          S_FILL: begin
            if (i_in_valid) begin
              r_wr_en   <= 1'b1;
              r_wr_sel  <= r_counter;
              r_wr_data <= i_in_data;
              if (r_wr_count != FULL_CNT) r_wr_count <= r_wr_count + (ADDR_W + 1)'(1);
              if (r_counter == LAST_SEL) begin
                r_counter <= '0;
                r_state   <= S_DONE;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
              end else begin
                r_counter <= r_counter + ADDR_W'(1);
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_sel   = r_wr_sel;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_wr_count = r_wr_count;

endmodule
